// File: rtl/reset_run_sequencer.sv
// reset_run_sequencer: drives a core's active-low reset through NUM_RUNS
// hold->run windows after each start, counting run cycles and heartbeats,
// with an optional no-progress watchdog that ends the sequence early.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-low reset
//   i_start      one-cycle pulse, begins a sequence (accepted in IDLE/FINISH)
//   i_abort      ends the sequence at the next edge (ignored in IDLE/FINISH)
//   i_heartbeat  core progress pulse, only counted while in RUN
//   o_core_rst   active-low core reset, 1 only while in RUN
//   o_running    1 while in RUN
//   o_run_idx    0-based index of the current/last run window
//   o_cycle_cnt  RUN cycles elapsed in the current window
//   o_hb_cnt     heartbeats seen in RUN since the last start
//   o_done       sticky, sequence ended (normal end, abort or timeout)
//   o_timeout    sticky, watchdog fired
module reset_run_sequencer #(
  parameter int unsigned POR_CYCLES  = 2,
  parameter int unsigned HOLD_CYCLES = 50,
  parameter int unsigned RUN_CYCLES  = 500,
  parameter int unsigned NUM_RUNS    = 2,
  parameter int unsigned WDOG_CYCLES = 0,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_heartbeat,
  output logic             o_core_rst,
  output logic             o_running,
  output logic [IDX_W-1:0] o_run_idx,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_hb_cnt,
  output logic             o_done,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_hb_cnt;
  logic [IDX_W-1:0] r_run_idx;
  logic             r_core_rst;
  logic             r_running;
  logic             r_done;
  logic             r_timeout;

  logic [CNT_W-1:0] w_cycle_inc;
  logic [CNT_W-1:0] w_idle_nxt;
  logic             w_wdog_fire;
  logic             w_run_end;
  logic             w_last_run;
  logic             w_hold_end;

  // Values the RUN cycle ending at this edge will commit.
  assign w_cycle_inc = r_cycle_cnt + CNT_W'(1);
  // A heartbeat in the final idle cycle clears the count before it can fire.
  assign w_idle_nxt  = i_heartbeat ? '0 : (r_idle_cnt + CNT_W'(1));
  assign w_wdog_fire = (WDOG_CYCLES != 0) && (w_idle_nxt == CNT_W'(WDOG_CYCLES));
  assign w_run_end   = (w_cycle_inc == CNT_W'(RUN_CYCLES));
  assign w_last_run  = (r_run_idx == IDX_W'(NUM_RUNS - 1));
  // Hold counter is loaded with the full length; the cycle it reads 1 is the last.
  assign w_hold_end  = (r_hold_cnt == CNT_W'(1));

  // Sequencer state machine with registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_hold_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_hb_cnt    <= '0;
      r_run_idx   <= '0;
      r_core_rst  <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FINISH: begin
          if (i_start) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= CNT_W'(POR_CYCLES);
            r_run_idx  <= '0;
            r_hb_cnt   <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (i_abort) begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
          end else if (w_hold_end) begin
            r_state     <= ST_RUN;
            r_core_rst  <= 1'b1;
            r_running   <= 1'b1;
            r_cycle_cnt <= '0;
            r_idle_cnt  <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt - CNT_W'(1);
          end
        end

        ST_RUN: begin
          // The cycle being closed is counted even when the sequence ends here.
          r_cycle_cnt <= w_cycle_inc;
          r_idle_cnt  <= w_idle_nxt;
          if (i_heartbeat) begin
            r_hb_cnt <= r_hb_cnt + CNT_W'(1);
          end
          if (i_abort) begin
            r_state    <= ST_FINISH;
            r_core_rst <= 1'b0;
            r_running  <= 1'b0;
            r_done     <= 1'b1;
          end else if (w_wdog_fire) begin
            r_state    <= ST_FINISH;
            r_core_rst <= 1'b0;
            r_running  <= 1'b0;
            r_done     <= 1'b1;
            r_timeout  <= 1'b1;
          end else if (w_run_end) begin
            r_core_rst <= 1'b0;
            r_running  <= 1'b0;
            if (w_last_run) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_HOLD;
              r_hold_cnt <= CNT_W'(HOLD_CYCLES);
              r_run_idx  <= r_run_idx + IDX_W'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_core_rst  = r_core_rst;
  assign o_running   = r_running;
  assign o_run_idx   = r_run_idx;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_hb_cnt    = r_hb_cnt;
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_reset_run_sequencer.sv
// Bench for reset_run_sequencer: three instances (default parameters, a
// watchdog-enabled multi-run setup, and a minimal single 1-cycle run) are
// compared every cycle against a schedule-arithmetic reference model, plus
// directed scenarios with fixed expected values.
module tb_reset_run_sequencer;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned IDX_W = 8;
  localparam int NI = 3;

  typedef struct {
    int por;
    int hold;
    int run;
    int nruns;
    int wdog;
  } cfg_t;

  // k counts edges since the accepted start; position in the schedule is derived from it.
  typedef struct {
    bit busy;
    int k;
    int idx;
    int cyc;
    int hb;
    int idle;
    bit done;
    bit tmo;
  } mdl_t;

  logic clk;
  logic rst_n [NI];
  logic start [NI];
  logic abort [NI];
  logic hbeat [NI];
  logic core_rst [NI];
  logic running [NI];
  logic done [NI];
  logic tmo [NI];
  logic [IDX_W-1:0] run_idx [NI];
  logic [CNT_W-1:0] cyc [NI];
  logic [CNT_W-1:0] hbc [NI];

  cfg_t cfg [NI];
  mdl_t mdl [NI];
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reset_run_sequencer u_def (
    .i_clk(clk), .i_rst(rst_n[0]), .i_start(start[0]), .i_abort(abort[0]),
    .i_heartbeat(hbeat[0]), .o_core_rst(core_rst[0]), .o_running(running[0]),
    .o_run_idx(run_idx[0]), .o_cycle_cnt(cyc[0]), .o_hb_cnt(hbc[0]),
    .o_done(done[0]), .o_timeout(tmo[0])
  );

  reset_run_sequencer #(
    .POR_CYCLES(3), .HOLD_CYCLES(4), .RUN_CYCLES(30), .NUM_RUNS(3),
    .WDOG_CYCLES(8), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) u_wd (
    .i_clk(clk), .i_rst(rst_n[1]), .i_start(start[1]), .i_abort(abort[1]),
    .i_heartbeat(hbeat[1]), .o_core_rst(core_rst[1]), .o_running(running[1]),
    .o_run_idx(run_idx[1]), .o_cycle_cnt(cyc[1]), .o_hb_cnt(hbc[1]),
    .o_done(done[1]), .o_timeout(tmo[1])
  );

  reset_run_sequencer #(
    .POR_CYCLES(1), .HOLD_CYCLES(1), .RUN_CYCLES(1), .NUM_RUNS(1),
    .WDOG_CYCLES(0), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) u_one (
    .i_clk(clk), .i_rst(rst_n[2]), .i_start(start[2]), .i_abort(abort[2]),
    .i_heartbeat(hbeat[2]), .o_core_rst(core_rst[2]), .o_running(running[2]),
    .o_run_idx(run_idx[2]), .o_cycle_cnt(cyc[2]), .o_hb_cnt(hbc[2]),
    .o_done(done[2]), .o_timeout(tmo[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Schedule after start: por hold cycles, then repeating (run, hold) periods.
  function automatic bit in_run(input cfg_t c, input int k, output int j, output int r);
    if (k < c.por) begin
      j = 0;
      r = -1;
      return 1'b0;
    end
    j = (k - c.por) / (c.run + c.hold);
    r = (k - c.por) % (c.run + c.hold);
    return (r < c.run);
  endfunction

  function automatic mdl_t step(input cfg_t c, input mdl_t m, input bit rn,
                                input bit st, input bit ab, input bit hbt);
    mdl_t n;
    int   j;
    int   r;
    bit   run_now;
    bit   run_nxt;
    n = m;
    if (!rn) begin
      n = '{default: 0};
      return n;
    end
    if (!m.busy) begin
      if (st) begin
        n.busy = 1'b1;
        n.k    = 0;
        n.idx  = 0;
        n.hb   = 0;
        n.done = 1'b0;
        n.tmo  = 1'b0;
      end
      return n;
    end
    run_now = in_run(c, m.k, j, r);
    if (run_now) begin
      n.cyc  = r + 1;
      n.hb   = m.hb + int'(hbt);
      n.idle = hbt ? 0 : m.idle + 1;
    end
    if (ab) begin
      n.busy = 1'b0;
      n.done = 1'b1;
      return n;
    end
    if (run_now && c.wdog != 0 && n.idle == c.wdog) begin
      n.busy = 1'b0;
      n.done = 1'b1;
      n.tmo  = 1'b1;
      return n;
    end
    if (run_now && (r + 1 == c.run) && (j == c.nruns - 1)) begin
      n.busy = 1'b0;
      n.done = 1'b1;
      return n;
    end
    n.k = m.k + 1;
    run_nxt = in_run(c, n.k, j, r);
    if (run_nxt) begin
      if (r == 0) begin
        n.cyc  = 0;
        n.idle = 0;
      end
    end else if (r >= c.run) begin
      n.idx = j + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      mdl[i] <= step(cfg[i], mdl[i], rst_n[i], start[i], abort[i], hbeat[i]);
    end
  end

  always @(negedge clk) begin : p_scoreboard
    int j;
    int r;
    bit er;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        er = in_run(cfg[i], mdl[i].k, j, r) && mdl[i].busy;
        chk($sformatf("u%0d.core_rst", i), 64'(core_rst[i]), 64'(er));
        chk($sformatf("u%0d.running", i), 64'(running[i]), 64'(er));
        chk($sformatf("u%0d.run_idx", i), 64'(run_idx[i]), 64'(mdl[i].idx));
        chk($sformatf("u%0d.cycle_cnt", i), 64'(cyc[i]), 64'(mdl[i].cyc));
        chk($sformatf("u%0d.hb_cnt", i), 64'(hbc[i]), 64'(mdl[i].hb));
        chk($sformatf("u%0d.done", i), 64'(done[i]), 64'(mdl[i].done));
        chk($sformatf("u%0d.timeout", i), 64'(tmo[i]), 64'(mdl[i].tmo));
      end
    end
  end

  int seg[$];
  int exp_seg [4];
  int pct [NI];

  initial begin
    int   cur;
    int   len;
    int   budget;
    int   got_seg;

    cfg[0] = '{2, 50, 500, 2, 0};
    cfg[1] = '{3, 4, 30, 3, 8};
    cfg[2] = '{1, 1, 1, 1, 0};
    exp_seg = '{2, 500, 50, 500};
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      abort[i] = 1'b0;
      hbeat[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;

    // Reset values, with start held high during reset.
    start[0] = 1'b1;
    @(negedge clk);
    chk("rst.core_rst", 64'(core_rst[0]), 64'd0);
    chk("rst.running", 64'(running[0]), 64'd0);
    chk("rst.run_idx", 64'(run_idx[0]), 64'd0);
    chk("rst.cycle_cnt", 64'(cyc[0]), 64'd0);
    chk("rst.hb_cnt", 64'(hbc[0]), 64'd0);
    chk("rst.done", 64'(done[0]), 64'd0);
    chk("rst.timeout", 64'(tmo[0]), 64'd0);
    start[0] = 1'b0;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    @(negedge clk);

    // Default sequence: core_rst pattern 0x2, 1x500, 0x50, 1x500; heartbeat only in run 0.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    seg.delete();
    cur = int'(core_rst[0]);
    len = 0;
    budget = 0;
    while (!done[0] && budget < 3000) begin
      hbeat[0] = running[0] && (run_idx[0] == 8'd0);
      if (int'(core_rst[0]) == cur) len++;
      else begin
        seg.push_back(len);
        cur = int'(core_rst[0]);
        len = 1;
      end
      @(negedge clk);
      budget++;
    end
    seg.push_back(len);
    hbeat[0] = 1'b0;
    chk("t1.seg_count", 64'(seg.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      got_seg = (i < seg.size()) ? seg[i] : -1;
      chk($sformatf("t1.seg%0d_len", i), 64'(got_seg), 64'(exp_seg[i]));
    end
    chk("t1.done", 64'(done[0]), 64'd1);
    chk("t1.run_idx", 64'(run_idx[0]), 64'd1);
    chk("t1.timeout", 64'(tmo[0]), 64'd0);
    chk("t1.core_rst", 64'(core_rst[0]), 64'd0);
    chk("t2.hb_cnt", 64'(hbc[0]), 64'd500);
    chk("t1.cycle_cnt", 64'(cyc[0]), 64'd500);

    // Abort on RUN cycle 100 of run 0, then restart.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    budget = 0;
    while (!running[0] && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("t4.reach_run", 64'(running[0]), 64'd1);
    for (int c = 1; c < 100; c++) begin
      hbeat[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    hbeat[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    hbeat[0] = 1'b0;
    chk("t4.done", 64'(done[0]), 64'd1);
    chk("t4.run_idx", 64'(run_idx[0]), 64'd0);
    chk("t4.cycle_cnt", 64'(cyc[0]), 64'd100);
    chk("t4.timeout", 64'(tmo[0]), 64'd0);
    chk("t4.core_rst", 64'(core_rst[0]), 64'd0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("t4.restart_hb_cnt", 64'(hbc[0]), 64'd0);
    chk("t4.restart_done", 64'(done[0]), 64'd0);

    // Reset during HOLD of run 1 wins over start.
    budget = 0;
    while (!(run_idx[0] == 8'd1 && !running[0]) && budget < 1000) begin
      hbeat[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      budget++;
    end
    hbeat[0] = 1'b0;
    chk("t5.reach_hold1", 64'(run_idx[0]), 64'd1);
    rst_n[0] = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    chk("t5.run_idx", 64'(run_idx[0]), 64'd0);
    chk("t5.hb_cnt", 64'(hbc[0]), 64'd0);
    chk("t5.cycle_cnt", 64'(cyc[0]), 64'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5.idle_core_rst", 64'(core_rst[0]), 64'd0);
    chk("t5.idle_done", 64'(done[0]), 64'd0);

    // Watchdog: heartbeat for run cycles 1..20, then silence.
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    budget = 0;
    while (!done[1] && budget < 200) begin
      hbeat[1] = running[1] && (cyc[1] < 32'd20);
      @(negedge clk);
      budget++;
    end
    hbeat[1] = 1'b0;
    chk("t3.timeout", 64'(tmo[1]), 64'd1);
    chk("t3.done", 64'(done[1]), 64'd1);
    chk("t3.core_rst", 64'(core_rst[1]), 64'd0);
    chk("t3.cycle_cnt", 64'(cyc[1]), 64'd28);
    chk("t3.hb_cnt", 64'(hbc[1]), 64'd20);
    repeat (2) @(negedge clk);
    chk("t3.cycle_frozen", 64'(cyc[1]), 64'd28);

    // Single 1-cycle run; start coinciding with done is ignored, next one restarts.
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    chk("t6.hold_core_rst", 64'(core_rst[2]), 64'd0);
    @(negedge clk);
    chk("t6.run_core_rst", 64'(core_rst[2]), 64'd1);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    chk("t6.done", 64'(done[2]), 64'd1);
    chk("t6.cycle_cnt", 64'(cyc[2]), 64'd1);
    chk("t6.end_core_rst", 64'(core_rst[2]), 64'd0);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    chk("t6.restart_done", 64'(done[2]), 64'd0);
    @(negedge clk);
    chk("t6.rerun_core_rst", 64'(core_rst[2]), 64'd1);
    @(negedge clk);

    // Randomized traffic on all instances, scored by the model every cycle.
    for (int i = 0; i < NI; i++) pct[i] = 50;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (c % 150 == 0) begin
          case ($urandom_range(0, 3))
            0: pct[i] = 0;
            1: pct[i] = 30;
            2: pct[i] = 80;
            default: pct[i] = 100;
          endcase
        end
        rst_n[i] = ($urandom_range(0, 299) != 0);
        start[i] = ($urandom_range(0, 24) == 0);
        abort[i] = ($urandom_range(0, 149) == 0);
        hbeat[i] = (int'($urandom_range(0, 99)) < pct[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      hbeat[i] = 1'b0;
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
